// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - timekeeping, adjust and alarm datapath driven by the mode code
module clock_time_core #(
  parameter int TIMEOUT_S   = 60,
  parameter int ALARM_H_RST = 6,
  parameter int ALARM_M_RST = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [1:0] moDe,
  input  logic       up,
  input  logic       campo,
  input  logic       apagar,
  output logic [4:0] hora,
  output logic [5:0] minuto,
  output logic [5:0] segundo,
  output logic [4:0] alarma_hora,
  output logic [5:0] alarma_min,
  output logic       sonar,
  output logic       show_alarm
);

  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;
  localparam logic [1:0] MODE_ARMED     = 2'd3;

  localparam logic [4:0] ALARM_H_INIT = 5'(ALARM_H_RST);
  localparam logic [5:0] ALARM_M_INIT = 6'(ALARM_M_RST);
  localparam logic [5:0] BUZZ_LAST    = 6'(TIMEOUT_S - 1);

  logic       up_q;
  logic [1:0] mode_q;
  logic [5:0] buzz_cnt;

  logic       up_pulse;
  logic       trigger;
  logic       sonar_clear;
  logic [5:0] min_inc;
  logic [4:0] hour_inc;
  logic [5:0] amin_inc;
  logic [4:0] ahour_inc;
  logic [5:0] sec_next;
  logic [5:0] min_next;
  logic [4:0] hour_next;

  // Wrapping increments and the time as it will read after a counting tick
  always_comb begin
    up_pulse    = up & ~up_q;
    min_inc     = (minuto == 6'd59) ? 6'd0 : minuto + 6'd1;
    hour_inc    = (hora == 5'd23) ? 5'd0 : hora + 5'd1;
    amin_inc    = (alarma_min == 6'd59) ? 6'd0 : alarma_min + 6'd1;
    ahour_inc   = (alarma_hora == 5'd23) ? 5'd0 : alarma_hora + 5'd1;
    sec_next    = (segundo == 6'd59) ? 6'd0 : segundo + 6'd1;
    min_next    = (segundo == 6'd59) ? min_inc : minuto;
    hour_next   = (segundo == 6'd59 && minuto == 6'd59) ? hour_inc : hora;
    // Only the tick that lands exactly on hh:mm:00 fires, so arming mid-minute stays quiet
    trigger     = (moDe == MODE_ARMED) && tick_1hz &&
                  (hour_next == alarma_hora) && (min_next == alarma_min) && (sec_next == 6'd0);
    sonar_clear = apagar || (moDe != MODE_ARMED);
  end

  // Running time: frozen and hand-adjusted in SET_TIME, counting on ticks otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      hora    <= 5'd0;
      minuto  <= 6'd0;
      segundo <= 6'd0;
    end else if (moDe == MODE_SET_TIME) begin
      if (mode_q != MODE_SET_TIME) begin
        segundo <= 6'd0;
      end
      if (up_pulse) begin
        if (campo) begin
          hora <= hour_inc;
        end else begin
          minuto <= min_inc;
        end
      end
    end else if (tick_1hz) begin
      hora    <= hour_next;
      minuto  <= min_next;
      segundo <= sec_next;
    end
  end

  // Alarm set-point, adjusted only in SET_ALARM
  always_ff @(posedge clk) begin
    if (reset) begin
      alarma_hora <= ALARM_H_INIT;
      alarma_min  <= ALARM_M_INIT;
    end else if (moDe == MODE_SET_ALARM && up_pulse) begin
      if (campo) begin
        alarma_hora <= ahour_inc;
      end else begin
        alarma_min <= amin_inc;
      end
    end
  end

  // Edge-detect history, mode history and the registered display select
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q       <= 1'b0;
      mode_q     <= 2'd0;
      show_alarm <= 1'b0;
    end else begin
      up_q       <= up;
      mode_q     <= moDe;
      show_alarm <= (moDe == MODE_SET_ALARM);
    end
  end

  // Buzzer request: acknowledge or leaving ARMED wins over a fresh trigger
  always_ff @(posedge clk) begin
    if (reset) begin
      sonar    <= 1'b0;
      buzz_cnt <= 6'd0;
    end else if (sonar_clear) begin
      sonar <= 1'b0;
    end else if (trigger) begin
      sonar    <= 1'b1;
      buzz_cnt <= 6'd0;
    end else if (sonar && tick_1hz) begin
      if (buzz_cnt == BUZZ_LAST) begin
        sonar <= 1'b0;
      end else begin
        buzz_cnt <= buzz_cnt + 6'd1;
      end
    end
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Timekeeping and adjust datapath that directly consumes the 2-bit mode code from the mode-selector stage.
- Holds the running time (hh:mm:ss) and the alarm set-point (hh:mm).
- Applies "up" button presses to the field chosen by the current mode.
- Drives the alarm buzzer request and the display source select for the downstream display driver.

Parameters:
- TIMEOUT_S, 60, seconds the buzzer stays on without acknowledgement (1..63)
- ALARM_H_RST, 6, alarm hour after reset (0..23)
- ALARM_M_RST, 0, alarm minute after reset (0..59)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick_1hz  input  1  one-cycle enable, once per second
- moDe  input  2  mode code: 0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 ARMED
- up  input  1  synchronized, debounced button level; the block acts on its rising edge
- campo  input  1  field select for adjust: 0 = minutes, 1 = hours
- apagar  input  1  alarm acknowledge (level)
- hora  output  5  current hour, 0..23
- minuto  output  6  current minute, 0..59
- segundo  output  6  current second, 0..59
- alarma_hora  output  5  alarm hour
- alarma_min  output  6  alarm minute
- sonar  output  1  buzzer request
- show_alarm  output  1  display shows the alarm fields when 1

Behaviour:
- Synchronous, active-high reset. On reset:
  - hora, minuto, segundo = 0
  - alarma_hora = ALARM_H_RST, alarma_min = ALARM_M_RST
  - sonar = 0, show_alarm = 0
  - internal up_q = 0, mode_q = 0, buzz_cnt = 0
- Reset has priority over every other input in any cycle.
- Edge detect:
  - up_q <= up every cycle.
  - up_pulse = up & ~up_q.
  - Holding up produces exactly one increment.
- mode_q <= moDe every cycle; used for entry detection.
- Time counting (moDe = 0, 2 or 3) on tick_1hz:
  - segundo +1; 59 -> 0 with carry into minuto.
  - minuto 59 -> 0 with carry into hora.
  - hora 23 -> 0.
  - 23:59:59 -> 00:00:00 in one edge.
- moDe = 1 (SET_TIME):
  - tick_1hz is ignored; time is frozen.
  - On the first cycle with moDe = 1 and mode_q != 1, segundo <= 0.
  - up_pulse increments minuto (campo = 0) or hora (campo = 1).
  - Wrap 59 -> 0 or 23 -> 0 with no carry between fields.
- moDe = 2 (SET_ALARM):
  - Time keeps counting.
  - up_pulse increments alarma_min or alarma_hora per campo, same wrap rules, no carry.
  - If tick_1hz and up_pulse coincide, both updates apply in the same edge.
- moDe = 0 or 3: up_pulse is ignored. Leaving SET_TIME resumes counting from the held value on the next tick.
- show_alarm is registered: show_alarm <= (moDe == 2). One-cycle latency.
- Alarm trigger:
  - Condition: moDe = 3, tick_1hz = 1, and the post-increment time equals alarma_hora:alarma_min:00.
  - Action: sonar <= 1, buzz_cnt <= 0.
  - Arming in mode 3 while the time already sits in the matching minute does not trigger; only the tick into second 00 does.
- While sonar = 1:
  - buzz_cnt increments on each tick_1hz.
  - sonar clears on the tick where buzz_cnt reaches TIMEOUT_S-1, so the buzzer is on for TIMEOUT_S ticks.
- sonar clears on the next edge if apagar = 1 or moDe != 3.
- Priority: clear beats trigger when both occur in the same cycle.
- Time fields are only ever written through wrap logic; out-of-range values are unreachable.

Test Plan:
- Reset, moDe=0, 61 ticks -> 00:01:01. Preset 23:59:59 via SET_TIME plus counting, then one tick -> 00:00:00.
- moDe=1 at 00:00:37 -> segundo=0 one cycle after entry. campo=1, up held 10 cycles, released, 24 pulses total -> hora increments exactly once per press and ends at 0. Ticks during moDe=1 leave the time unchanged.
- moDe=2, campo=0, 61 up presses -> alarma_min=1. show_alarm=1 one cycle after moDe=2 and 0 one cycle after exit. A tick coincident with an up press advances both segundo and alarma_min.
- Alarm 06:00, time 05:59:58, moDe=3, two ticks -> sonar=1 after the second tick. No apagar -> sonar=0 after TIMEOUT_S (60) ticks.
- sonar=1 then apagar=1 for one cycle -> sonar=0 next edge. With trigger and apagar in the same cycle -> sonar stays 0.
- Same alarm scenario but moDe=0 -> sonar never asserts. sonar=1 then moDe changes 3->2 -> sonar=0 next edge. reset asserted mid-buzz -> all outputs return to reset values at the next edge.
